// File: rtl/can_pkg.sv
// can_pkg: shared CAN state codes, CRC-15 polynomial and frame field lengths.
package can_pkg;
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_HDR     = 4'd1;
  localparam logic [3:0] ST_DATA    = 4'd2;
  localparam logic [3:0] ST_CRC     = 4'd3;
  localparam logic [3:0] ST_CRC_DEL = 4'd4;
  localparam logic [3:0] ST_ACK     = 4'd5;
  localparam logic [3:0] ST_ACK_DEL = 4'd6;
  localparam logic [3:0] ST_EOF     = 4'd7;
  localparam logic [3:0] ST_IFS     = 4'd8;
  localparam logic [14:0] CRC15_POLY = 15'h4599;
  localparam int HDR_BITS    = 19;
  localparam int CRC_BITS    = 15;
  localparam int EOF_BITS    = 7;
  localparam int IFS_BITS    = 3;
  localparam int STUFF_LIMIT = 5;
  function automatic logic [3:0] dlc_bytes(input logic [3:0] dlc);
    return dlc > 4'd8 ? 4'd8 : dlc;
  endfunction
endpackage

// File: rtl/can_crc15.sv
// can_crc15: serial CAN CRC-15, one message bit per enabled clock.
module can_crc15
  import can_pkg::*;
(
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Clr,
  input  logic        i_En,
  input  logic        i_Bit,
  output logic [14:0] o_Crc
);
  logic [14:0] r_crc;
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) r_crc <= '0;
    else if (i_Clr) r_crc <= '0;
    else if (i_En) r_crc <= {r_crc[13:0], 1'b0} ^ ((r_crc[14] ^ i_Bit) ? CRC15_POLY : 15'd0);
  assign o_Crc = r_crc;
endmodule

// File: rtl/can_frame_tx.sv
// can_frame_tx: CAN 2.0A data frame serializer with CRC-15 and bit stuffing.
// Define CAN_TX_ACK_CHECK_EN to add i_Rx_Serial / o_Ack_Err ACK-slot checking.
module can_frame_tx
  import can_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
`ifdef CAN_TX_ACK_CHECK_EN
  input  logic        i_Rx_Serial,
  output logic        o_Ack_Err,
`endif
  input  logic        i_Tx_DV,
  input  logic [10:0] i_Id,
  input  logic [3:0]  i_Dlc,
  input  logic [63:0] i_Data,
  output logic        o_Tx_Serial,
  output logic        o_Tx_Active,
  output logic        o_Tx_Ready,
  output logic        o_Tx_Done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  logic [3:0]    r_state;
  logic [5:0]    r_ptr;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_run;
  logic          r_last, r_stuff, r_serial, r_active, r_done;
  logic [10:0]   r_id;
  logic [3:0]    r_dlc, r_nb;
  logic [63:0]   r_data;
  logic [14:0]   w_crc;
  logic [18:0]   w_hdr;
  logic [5:0]    w_dend;
  logic [2:0]    w_run_n;
  logic [3:0]    w_nstate;
  logic          w_tick, w_bit, w_stuffing, w_fdone, w_end, w_accept, w_crc_en;
  assign w_tick     = r_baud == BW'(CLKS_PER_BIT - 1);
  assign w_hdr      = {1'b0, r_id, 3'b000, r_dlc};
  assign w_dend     = 6'(({3'b0, r_nb} << 3) - 7'd1);
  assign w_accept   = i_Tx_DV && r_state == ST_IDLE;
  assign w_stuffing = r_state == ST_HDR || r_state == ST_DATA || r_state == ST_CRC;
  assign w_bit = r_state == ST_HDR  ? w_hdr[5'd18 - r_ptr[4:0]] :
                 r_state == ST_DATA ? r_data[6'd63 - r_ptr] :
                 r_state == ST_CRC  ? w_crc[4'd14 - r_ptr[3:0]] : 1'b1;
  assign w_run_n = (r_run != 3'd0 && w_bit == r_last) ? r_run + 3'd1 : 3'd1;
  assign w_fdone = r_state == ST_HDR  ? r_ptr == 6'(HDR_BITS - 1) :
                   r_state == ST_DATA ? r_ptr == w_dend :
                   r_state == ST_CRC  ? r_ptr == 6'(CRC_BITS - 1) :
                   r_state == ST_EOF  ? r_ptr == 6'(EOF_BITS - 1) :
                   r_state == ST_IFS  ? r_ptr == 6'(IFS_BITS - 1) : 1'b1;
  assign w_nstate = r_state == ST_HDR     ? (r_nb == 4'd0 ? ST_CRC : ST_DATA) :
                    r_state == ST_DATA    ? ST_CRC :
                    r_state == ST_CRC     ? ST_CRC_DEL :
                    r_state == ST_CRC_DEL ? ST_ACK :
                    r_state == ST_ACK     ? ST_ACK_DEL :
                    r_state == ST_ACK_DEL ? ST_EOF :
                    r_state == ST_EOF     ? ST_IFS : ST_IDLE;
  assign w_end    = r_state == ST_IFS && w_fdone && w_tick;
  // CRC absorbs each header/data bit as it finishes, so it is final on entry to CRC
  assign w_crc_en = w_tick && !r_stuff && (r_state == ST_HDR || r_state == ST_DATA);
  can_crc15 u_crc (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .i_Clr  (w_accept),
    .i_En   (w_crc_en),
    .i_Bit  (w_bit),
    .o_Crc  (w_crc)
  );
  // During a stuff bit, state/ptr already point at the next frame bit
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_baud   <= '0;
      r_run    <= '0;
      r_last   <= 1'b0;
      r_stuff  <= 1'b0;
      r_serial <= 1'b1;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_id     <= '0;
      r_dlc    <= '0;
      r_nb     <= '0;
      r_data   <= '0;
    end else begin
      r_serial <= r_stuff ? ~r_last : w_bit;
      r_active <= r_state != ST_IDLE && r_state != ST_IFS;
      r_done   <= w_end;
      if (w_accept) begin
        r_state <= ST_HDR;
        r_ptr   <= '0;
        r_baud  <= '0;
        r_run   <= '0;
        r_last  <= 1'b0;
        r_stuff <= 1'b0;
        r_id    <= i_Id;
        r_dlc   <= i_Dlc;
        r_nb    <= dlc_bytes(i_Dlc);
        r_data  <= i_Data;
      end else if (r_state != ST_IDLE) begin
        r_baud <= w_tick ? '0 : r_baud + BW'(1);
        if (w_tick && r_stuff) begin
          r_stuff <= 1'b0;
          r_last  <= ~r_last;
          r_run   <= 3'd1;
        end else if (w_tick) begin
          if (w_stuffing) begin
            r_last  <= w_bit;
            r_run   <= w_run_n;
            r_stuff <= w_run_n == 3'(STUFF_LIMIT);
          end
          r_state <= w_fdone ? w_nstate : r_state;
          r_ptr   <= w_fdone ? '0 : r_ptr + 6'd1;
        end
      end
    end
  assign o_Tx_Serial = r_serial;
  assign o_Tx_Active = r_active;
  assign o_Tx_Ready  = r_state == ST_IDLE;
  assign o_Tx_Done   = r_done;
`ifdef CAN_TX_ACK_CHECK_EN
  logic r_ack_err;
  always_ff @(posedge i_Clock or posedge i_Reset)
    if (i_Reset) r_ack_err <= 1'b0;
    else if (w_accept) r_ack_err <= 1'b0;
    else if (r_state == ST_ACK && r_baud == BW'(CLKS_PER_BIT / 2) && i_Rx_Serial) r_ack_err <= 1'b1;
  assign o_Ack_Err = r_ack_err;
`endif
endmodule

// File: doc/can_frame_tx.md
# can_frame_tx

Serializer for CAN 2.0A standard data frames. It is the transmit counterpart of `can_rx`. Given an 11-bit identifier, a DLC and up to 8 data bytes, it:
- builds the frame and computes CRC-15 on the fly;
- inserts stuff bits;
- drives one bit every CLKS_PER_BIT clocks on a single serial line.

Its output is sized to drive `can_rx` directly in loopback benches.

## Interface
- CLKS_PER_BIT, 10, clocks per CAN bit time (must be ≥2)
- i_Clock  in  1  system clock
- i_Reset  in  1  reset, asynchronous, active-high
- i_Tx_DV  in  1  start request, sampled only while o_Tx_Ready=1
- i_Id  in  11  identifier, sent MSB first
- i_Dlc  in  4  data length code; values 9..15 send 8 bytes, but the DLC field carries the raw value
- i_Data  in  64  data bytes; byte 0 = i_Data[63:56], sent MSB first
- o_Tx_Serial  out  1  bus bit: 0 = dominant, 1 = recessive
- o_Tx_Active  out  1  high from SOF through the end of EOF
- o_Tx_Ready  out  1  high when idle and able to accept i_Tx_DV
- o_Tx_Done  out  1  one-clock pulse when the frame plus intermission has completed

## Operation
- Request capture: when i_Tx_DV=1 and o_Tx_Ready=1, all inputs are latched into a frame register. Input changes after that have no effect on the frame in flight.
- Frame bit order:
  - SOF = 0
  - ID[10:0]
  - RTR = 0, IDE = 0, r0 = 0
  - DLC[3:0]
  - data: 8·min(DLC,8) bits
  - CRC[14:0]
  - CRC delimiter = 1
  - ACK slot = 1 (recessive)
  - ACK delimiter = 1
  - EOF: 7×1
  - intermission: 3×1
- States: IDLE, HDR (SOF..DLC, 19 bits), DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, IFS.
- Transitions:
  - IDLE→HDR on accepted request.
  - HDR→DATA, or HDR→CRC when the byte count is 0.
  - DATA→CRC after the last data bit.
  - CRC→CRC_DEL after 15 bits.
  - CRC_DEL→ACK→ACK_DEL, one bit each.
  - ACK_DEL→EOF.
  - EOF→IFS after 7 bits.
  - IFS→IDLE after 3 bits.
- CRC:
  - Polynomial 0x4599, register initialised to 0.
  - Covers SOF through the last data bit, unstuffed bits only.
  - Update per bit: nxt = crc[14] ^ bit; crc = {crc[13:0],0} ^ (nxt ? 0x4599 : 0).
- Bit stuffing:
  - Active in HDR, DATA and CRC only.
  - After 5 consecutive equal bits, one complement bit is inserted. The stuff bit starts a new run of length 1.
  - A stuff bit costs one bit time. The frame bit pointer and the CRC do not advance during it.
  - If the 5th equal bit is the last CRC bit, a stuff bit is still sent before CRC_DEL.
- In IDLE, o_Tx_Serial is held at 1.

## Timing
- Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Ready=1, o_Tx_Done=0. The FSM is in IDLE and all counters are 0.
- Accept edge is N. From edge N+1:
  - o_Tx_Serial=0 (SOF), o_Tx_Active=1, o_Tx_Ready=0.
- Every bit, including stuff bits, is held for exactly CLKS_PER_BIT clocks.
- o_Tx_Active falls at the start of the first IFS bit.
- At the end of the 3rd IFS bit:
  - o_Tx_Done=1 for one clock;
  - o_Tx_Ready=1 in the same cycle.
- A new request accepted in that same cycle starts SOF on the next edge (back-to-back frames).
- Bit count, unstuffed: 47 + 8·min(DLC,8) bits from SOF to Done. Stuff bits add to this.
- i_Tx_DV while busy is ignored. It is not queued.
- Reset mid-frame: outputs return to their reset values asynchronously. No partial EOF is sent.

## Configuration
- CAN_TX_ACK_CHECK_EN
- Defined:
  - Adds input i_Rx_Serial (1 bit) and output o_Ack_Err (1 bit, reset 0).
  - i_Rx_Serial is sampled at clock count CLKS_PER_BIT/2 of the ACK slot.
  - If the sample is 1, o_Ack_Err is set and held until the next accepted request.
  - The frame continues normally.
- Undefined: neither port exists, and the ACK slot is transmit-only.

## Structure
- Package `can_pkg` holds:
  - the state enum;
  - CRC15_POLY = 15'h4599;
  - field lengths: HDR_BITS=19, CRC_BITS=15, EOF_BITS=7, IFS_BITS=3, STUFF_LIMIT=5.
- One sub-module, `can_crc15`: serial CRC with clear, enable and bit inputs, and a 15-bit output. `can_rx` can reuse it.
- The top level contains the baud counter, bit pointer, stuff-run counter and FSM.

## Test plan
- Reset held with i_Tx_DV=1 → o_Tx_Serial=1, o_Tx_Ready=1, no activity. Release reset → frame starts 1 clock after the next accepted edge.
- ID=0x000, DLC=0:
  - CRC=0x0000.
  - The decoded stream shows a recessive stuff bit at bit times 6, 12 and 18.
  - Every run of dominant bits is ≤5 bits.
  - Done arrives after 47 + stuff-count bit times.
- ID=0x123, DLC=2, data=0xAB,0xCD:
  - Loop o_Tx_Serial into `can_rx`.
  - Decoded ID, DLC and data match.
  - CRC matches the bench reference model.
  - The unstuffed length is 63 bits.
- DLC=12 → exactly 64 data bits are sent, and the DLC field reads 1100.
- Second request pulsed mid-frame → ignored. A request held through the Done cycle → the next SOF follows immediately with no idle gap.
- With CAN_TX_ACK_CHECK_EN:
  - i_Rx_Serial=1 in the ACK slot → o_Ack_Err=1.
  - i_Rx_Serial=0 → o_Ack_Err stays 0.
  - Reset asserted mid-DATA → outputs return to reset values within the same cycle.
